// File: rtl/cmp_window_tracker.sv
// Windowed comparator tracker: folds a sample stream into per-window max/min
// and rise/fall/same trend counts, published with a one-cycle valid pulse.
module cmp_window_tracker #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 8,
  parameter int CW     = $clog2(WINDOW+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [CW-1:0]    rise_cnt,
  output logic [CW-1:0]    fall_cnt,
  output logic [CW-1:0]    same_cnt,
  output logic [CW-1:0]    fill_cnt
);

  typedef enum logic {EMPTY = 1'b0, ACC = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] max_v;
    logic [WIDTH-1:0] min_v;
    logic [CW-1:0]    rise;
    logic [CW-1:0]    fall;
    logic [CW-1:0]    same;
  } win_t;

  // G/E/L magnitude compare, same encoding as the upstream 4-bit comparator
  function automatic logic [2:0] cmp_gel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  state_t           state_q, state_d;
  win_t             work_q, work_d;
  win_t             res_q, res_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             out_valid_q, out_valid_d;
  logic             start, accum, done;
  logic [2:0]       gel;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = EMPTY;
    end else if (in_valid) begin
      case (state_q)
        EMPTY:   state_d = ACC;
        ACC:     state_d = (fill_q == CW'(WINDOW-1)) ? EMPTY : ACC;
        default: state_d = EMPTY;
      endcase
    end
  end

  // FSM outputs: clear always wins over an incoming sample
  always_comb begin
    start = (state_q == EMPTY) && in_valid && !clear;
    accum = (state_q == ACC)   && in_valid && !clear;
    done  = accum && (fill_q == CW'(WINDOW-1));
  end

  always_comb begin
    work_d      = work_q;
    res_d       = res_q;
    prev_d      = prev_q;
    fill_d      = fill_q;
    out_valid_d = 1'b0;
    gel         = cmp_gel(in_data, prev_q);
    if (clear) begin
      work_d = '0;
      prev_d = '0;
      fill_d = '0;
    end else if (start) begin
      work_d       = '0;
      work_d.max_v = in_data;
      work_d.min_v = in_data;
      prev_d       = in_data;
      fill_d       = CW'(1);
    end else if (accum) begin
      if (gel[2]) work_d.rise = work_q.rise + CW'(1);
      if (gel[1]) work_d.same = work_q.same + CW'(1);
      if (gel[0]) work_d.fall = work_q.fall + CW'(1);
      if (in_data > work_q.max_v) work_d.max_v = in_data;
      if (in_data < work_q.min_v) work_d.min_v = in_data;
      prev_d = in_data;
      fill_d = fill_q + CW'(1);
      // publish the updated values so the closing sample is included
      if (done) begin
        res_d       = work_d;
        out_valid_d = 1'b1;
        fill_d      = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q      <= '0;
      res_q       <= '0;
      prev_q      <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      work_q      <= work_d;
      res_q       <= res_d;
      prev_q      <= prev_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign max_val   = res_q.max_v;
  assign min_val   = res_q.min_v;
  assign rise_cnt  = res_q.rise;
  assign fall_cnt  = res_q.fall;
  assign same_cnt  = res_q.same;
  assign fill_cnt  = fill_q;

endmodule
